// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the PIPE datapath and its hazard/status controller.
// The datapath side is the master; the controller is the slave.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;
    logic             W_valid;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             set_cc;
    logic [1:0]       run_state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_stat, W_valid,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, run_state, cycle_cnt, retire_cnt, mispred_cnt, stall_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_stat, W_valid,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, run_state, cycle_cnt, retire_cnt, mispred_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// PIPE Y86-64 pipeline control: stall/bubble decisions, CC write gating,
// RUN/DRAIN/HALTED status machine and wrap-around performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10,
        BAD    = 2'b11
    } runState_t;

    runState_t        state;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] retireCnt;
    logic [CNT_W-1:0] mispredCnt;
    logic [CNT_W-1:0] stallCnt;

    logic loadUse, retPend, mispred, excM, excW, active;
    logic fStall, dStall, dBubble, eBubble, mBubble, wStall, setCc;

    assign loadUse = (bus.E_icode == 4'd5 || bus.E_icode == 4'd11) && (bus.E_dstM != 4'hF)
                     && (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
    assign retPend = (bus.D_icode == 4'd9) || (bus.E_icode == 4'd9) || (bus.M_icode == 4'd9);
    assign mispred = (bus.E_icode == 4'd7) && !bus.e_Cnd;
    assign excM    = bus.m_stat != 3'd1;
    assign excW    = bus.W_stat != 3'd1;
    assign active  = (state == RUN) || (state == DRAIN);

    // The illegal encoding is treated like HALTED so the pipe stays frozen until it recovers.
    always_comb begin
        fStall  = 1'b0;
        dStall  = 1'b0;
        dBubble = 1'b0;
        eBubble = 1'b0;
        mBubble = 1'b0;
        wStall  = 1'b0;
        setCc   = 1'b0;
        if (rst_n) begin
            if (active) begin
                fStall  = loadUse || retPend;
                dStall  = loadUse;
                dBubble = mispred || (retPend && !loadUse);
                eBubble = mispred || loadUse;
                mBubble = excM || excW;
                wStall  = excW;
                setCc   = (bus.E_icode == 4'd6) && !excM && !excW;
            end else begin
                fStall  = 1'b1;
                dStall  = 1'b1;
                eBubble = 1'b1;
                mBubble = 1'b1;
                wStall  = 1'b1;
            end
        end
    end

    // Status machine and counters share one register block; everything freezes outside RUN/DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            cycleCnt   <= '0;
            retireCnt  <= '0;
            mispredCnt <= '0;
            stallCnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (excW && bus.W_valid)
                        state <= HALTED;
                    else if (excM)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (excW && bus.W_valid)
                        state <= HALTED;
                end
                HALTED: state <= HALTED;
                default: state <= HALTED;
            endcase
            if (active) begin
                cycleCnt <= cycleCnt + CNT_W'(1);
                if (bus.W_valid && bus.W_stat == 3'd1 && !wStall)
                    retireCnt <= retireCnt + CNT_W'(1);
                if (state == RUN && mispred)
                    mispredCnt <= mispredCnt + CNT_W'(1);
                if (fStall)
                    stallCnt <= stallCnt + CNT_W'(1);
            end
        end
    end

    assign bus.F_stall     = fStall;
    assign bus.D_stall     = dStall;
    assign bus.D_bubble    = dBubble;
    assign bus.E_bubble    = eBubble;
    assign bus.M_bubble    = mBubble;
    assign bus.W_stall     = wStall;
    assign bus.set_cc      = setCc;
    assign bus.run_state   = state;
    assign bus.cycle_cnt   = cycleCnt;
    assign bus.retire_cnt  = retireCnt;
    assign bus.mispred_cnt = mispredCnt;
    assign bus.stall_cnt   = stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand-written corner
// sequences and randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic [3:0] dIcode;
        logic [3:0] srcA;
        logic [3:0] srcB;
        logic [3:0] eIcode;
        logic [3:0] eDstM;
        logic       eCnd;
        logic [3:0] mIcode;
        logic [2:0] mStat;
        logic [2:0] wStat;
        logic       wValid;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [6:0] exp;
        string      name;
    } row_t;

    localparam logic [6:0] HALT_CTL = 7'b1101110;

    logic clk;
    logic rst_n;
    logic rstW_n;
    int   checks;
    int   errors;

    // Reference model state: 0=RUN, 1=DRAIN, 2=HALTED; counters kept as plain integers.
    int      mState;
    longint  mCycle, mRetire, mMispred, mStall;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  busW ();

    pipe_hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    pipe_hazard_ctrl #(.CNT_W(4))  dutW (.clk(clk), .rst_n(rstW_n), .bus(busW.slave));

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] dI, input logic [3:0] sA, input logic [3:0] sB,
                                input logic [3:0] eI, input logic [3:0] eD, input logic c,
                                input logic [3:0] mI, input logic [2:0] mS, input logic [2:0] wS,
                                input logic wV);
        vec_t v;
        v.dIcode = dI; v.srcA = sA; v.srcB = sB; v.eIcode = eI; v.eDstM = eD;
        v.eCnd = c; v.mIcode = mI; v.mStat = mS; v.wStat = wS; v.wValid = wV;
        return v;
    endfunction

    function automatic vec_t idleVec();
        return mk(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b1, 4'd1, 3'd1, 3'd1, 1'b0);
    endfunction

    // Expected {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc} for a state.
    function automatic logic [6:0] modelCtl(input vec_t v, input int st);
        bit lu, rp, mp, em, ew;
        if (st == 2) return HALT_CTL;
        lu = (v.eIcode == 4'd5 || v.eIcode == 4'd11) && v.eDstM != 4'hF
             && (v.eDstM == v.srcA || v.eDstM == v.srcB);
        rp = v.dIcode == 4'd9 || v.eIcode == 4'd9 || v.mIcode == 4'd9;
        mp = v.eIcode == 4'd7 && !v.eCnd;
        em = v.mStat != 3'd1;
        ew = v.wStat != 3'd1;
        return {lu || rp, lu, mp || (rp && !lu), mp || lu, em || ew, ew,
                v.eIcode == 4'd6 && !em && !ew};
    endfunction

    function automatic void modelReset();
        mState = 0; mCycle = 0; mRetire = 0; mMispred = 0; mStall = 0;
    endfunction

    function automatic void modelEdge(input vec_t v);
        logic [6:0] c;
        c = modelCtl(v, mState);
        if (mState != 2) begin
            mCycle++;
            if (v.wValid && v.wStat == 3'd1 && !c[1]) mRetire++;
            if (mState == 0 && v.eIcode == 4'd7 && !v.eCnd) mMispred++;
            if (c[6]) mStall++;
            if (v.wValid && v.wStat != 3'd1) mState = 2;
            else if (mState == 0 && v.mStat != 3'd1) mState = 1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.D_icode = v.dIcode; bus.d_srcA = v.srcA; bus.d_srcB = v.srcB;
        bus.E_icode = v.eIcode; bus.E_dstM = v.eDstM; bus.e_Cnd = v.eCnd;
        bus.M_icode = v.mIcode; bus.m_stat = v.mStat; bus.W_stat = v.wStat;
        bus.W_valid = v.wValid;
    endtask

    function automatic logic [6:0] dutCtl();
        return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                bus.M_bubble, bus.W_stall, bus.set_cc};
    endfunction

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic applyStimulus(input vec_t v, input bit useExp, input logic [6:0] expCtl,
                                 input string name);
        drive(v);
        #2;
        checkOutput({name, " ctl(model)"}, 64'(dutCtl()), 64'(modelCtl(v, mState)));
        if (useExp) checkOutput({name, " ctl"}, 64'(dutCtl()), 64'(expCtl));
        modelEdge(v);
        @(posedge clk);
        #1;
        checkOutput({name, " run_state"}, 64'(bus.run_state), 64'(mState));
        checkOutput({name, " cycle_cnt"}, 64'(bus.cycle_cnt), 64'(mCycle[31:0]));
        checkOutput({name, " retire_cnt"}, 64'(bus.retire_cnt), 64'(mRetire[31:0]));
        checkOutput({name, " mispred_cnt"}, 64'(bus.mispred_cnt), 64'(mMispred[31:0]));
        checkOutput({name, " stall_cnt"}, 64'(bus.stall_cnt), 64'(mStall[31:0]));
    endtask

    // Reset asserted between edges must clear everything before any clock arrives.
    task automatic asyncReset();
        drive(mk(4'd6, 4'd3, 4'hF, 4'd5, 4'd3, 1'b1, 4'd1, 3'd1, 3'd1, 1'b1));
        rst_n = 1'b0;
        #2;
        checkOutput("reset ctl", 64'(dutCtl()), 64'd0);
        checkOutput("reset run_state", 64'(bus.run_state), 64'd0);
        checkOutput("reset cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
        checkOutput("reset retire_cnt", 64'(bus.retire_cnt), 64'd0);
        checkOutput("reset mispred_cnt", 64'(bus.mispred_cnt), 64'd0);
        checkOutput("reset stall_cnt", 64'(bus.stall_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    row_t tbl[14];

    initial begin
        vec_t v;
        int haltCycles;
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        rstW_n = 1'b0;
        modelReset();
        drive(idleVec());
        busW.D_icode = 4'd1; busW.d_srcA = 4'hF; busW.d_srcB = 4'hF;
        busW.E_icode = 4'd1; busW.E_dstM = 4'hF; busW.e_Cnd = 1'b1;
        busW.M_icode = 4'd1; busW.m_stat = 3'd1; busW.W_stat = 3'd1; busW.W_valid = 1'b0;

        tbl[0]  = '{v: idleVec(), exp: 7'b0000000, name: "idle"};
        tbl[1]  = '{v: mk(4'd6, 4'd3, 4'hF, 4'd5, 4'd3, 1, 4'd1, 1, 1, 1), exp: 7'b1101000, name: "load_use mrmov"};
        tbl[2]  = '{v: mk(4'd6, 4'hF, 4'hF, 4'd5, 4'hF, 1, 4'd1, 1, 1, 1), exp: 7'b0000000, name: "no reg"};
        tbl[3]  = '{v: mk(4'd2, 4'd1, 4'd4, 4'd11, 4'd4, 1, 4'd1, 1, 1, 1), exp: 7'b1101000, name: "load_use popq srcB"};
        tbl[4]  = '{v: mk(4'd9, 4'hF, 4'hF, 4'd1, 4'hF, 1, 4'd1, 1, 1, 0), exp: 7'b1010000, name: "ret in D"};
        tbl[5]  = '{v: mk(4'd1, 4'hF, 4'hF, 4'd7, 4'hF, 0, 4'd1, 1, 1, 1), exp: 7'b0011000, name: "mispred"};
        tbl[6]  = '{v: mk(4'd1, 4'hF, 4'hF, 4'd7, 4'hF, 1, 4'd1, 1, 1, 1), exp: 7'b0000000, name: "taken jXX"};
        tbl[7]  = '{v: mk(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 1, 4'd1, 1, 1, 1), exp: 7'b0000001, name: "OPq set_cc"};
        tbl[8]  = '{v: mk(4'd9, 4'd2, 4'hF, 4'd5, 4'd2, 1, 4'd1, 1, 1, 0), exp: 7'b1101000, name: "load_use over ret"};
        tbl[9]  = '{v: mk(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1, 4'd9, 1, 1, 0), exp: 7'b1010000, name: "ret in M"};
        tbl[10] = '{v: mk(4'd1, 4'd5, 4'hF, 4'd5, 4'd6, 1, 4'd1, 1, 1, 0), exp: 7'b0000000, name: "dstM differs"};
        tbl[11] = '{v: mk(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 1, 4'd1, 3, 1, 0), exp: 7'b0000100, name: "exc_m gates cc"};
        tbl[12] = '{v: mk(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 1, 4'd1, 1, 4, 0), exp: 7'b0000110, name: "exc_w drain"};
        tbl[13] = '{v: mk(4'd6, 4'd7, 4'hF, 4'd5, 4'd7, 1, 4'd1, 1, 1, 1), exp: 7'b1101000, name: "load_use drain"};

        @(posedge clk);
        #1;
        drive(tbl[1].v);
        #1;
        checkOutput("in reset ctl", 64'(dutCtl()), 64'd0);
        drive(idleVec());
        rst_n = 1'b1;
        rstW_n = 1'b1;

        // 17 idle cycles: the 4-bit instance wraps back to 1.
        for (int i = 0; i < 17; i++) applyStimulus(idleVec(), 1'b1, 7'b0, "idle run");
        checkOutput("wrap cycle_cnt", 64'(busW.cycle_cnt), 64'd1);
        checkOutput("wrap run_state", 64'(busW.run_state), 64'd0);

        for (int i = 0; i < 14; i++) applyStimulus(tbl[i].v, 1'b1, tbl[i].exp, tbl[i].name);
        checkOutput("table ends in drain", 64'(bus.run_state), 64'd1);

        asyncReset();
        applyStimulus(tbl[5].v, 1'b1, 7'b0011000, "seq mispred");
        checkOutput("seq mispred_cnt", 64'(bus.mispred_cnt), 64'd1);
        applyStimulus(tbl[6].v, 1'b1, 7'b0000000, "seq taken");
        checkOutput("seq mispred_cnt held", 64'(bus.mispred_cnt), 64'd1);

        applyStimulus(mk(4'd9, 4'hF, 4'hF, 4'd1, 4'hF, 1, 4'd1, 1, 1, 0), 1'b1, 7'b1010000, "ret D");
        applyStimulus(mk(4'd1, 4'hF, 4'hF, 4'd9, 4'hF, 1, 4'd1, 1, 1, 0), 1'b1, 7'b1010000, "ret E");
        applyStimulus(mk(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1, 4'd9, 1, 1, 0), 1'b1, 7'b1010000, "ret M");
        applyStimulus(idleVec(), 1'b1, 7'b0000000, "ret done");
        checkOutput("ret stall_cnt", 64'(bus.stall_cnt), 64'd3);

        applyStimulus(tbl[11].v, 1'b1, 7'b0000100, "exc_m");
        checkOutput("exc_m to DRAIN", 64'(bus.run_state), 64'd1);
        applyStimulus(mk(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1, 4'd1, 1, 3, 1), 1'b1, 7'b0000110, "exc_w");
        checkOutput("exc_w to HALTED", 64'(bus.run_state), 64'd2);
        for (int i = 0; i < 10; i++)
            applyStimulus(mk(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 0, 4'd1, 1, 1, 1), 1'b1, HALT_CTL, "halted");

        asyncReset();
        applyStimulus(mk(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1, 4'd1, 1, 1, 1), 1'b1, 7'b0, "retire");
        applyStimulus(mk(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1, 4'd1, 1, 1, 1), 1'b1, 7'b0, "retire");
        applyStimulus(mk(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1, 4'd1, 1, 2, 1), 1'b1, 7'b0000110, "halt insn");
        checkOutput("halt direct", 64'(bus.run_state), 64'd2);
        checkOutput("halt not retired", 64'(bus.retire_cnt), 64'd2);

        asyncReset();
        haltCycles = 0;
        for (int i = 0; i < 600; i++) begin
            v.dIcode = 4'($urandom_range(0, 11));
            v.srcA   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            v.srcB   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            v.eIcode = 4'($urandom_range(0, 11));
            v.eDstM  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            v.eCnd   = 1'($urandom_range(0, 1));
            v.mIcode = 4'($urandom_range(0, 11));
            v.mStat  = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            v.wStat  = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            v.wValid = 1'($urandom_range(0, 1));
            applyStimulus(v, 1'b0, 7'b0, "random");
            haltCycles = (mState == 2) ? haltCycles + 1 : 0;
            if (haltCycles > 3) begin
                asyncReset();
                haltCycles = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage PIPE Y86-64 core. It sequences the execute datapath and its condition-code register.
- It decides per-cycle stall/bubble for the F/D/E/M/W pipeline registers (load/use, ret, mispredicted jXX) and gates CC writes (set_cc) on exceptions.
- It runs a RUN/DRAIN/HALTED status FSM and keeps wrap-around performance counters.
- Control outputs are combinational from state and inputs; the FSM and counters are registered.

Parameters:
CNT_W, 32, width of every performance counter

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
D_icode  input  4  icode in decode stage
d_srcA  input  4  decode srcA register id (15 = none)
d_srcB  input  4  decode srcB register id (15 = none)
E_icode  input  4  icode in execute stage
E_dstM  input  4  execute-stage dstM (15 = none)
e_Cnd  input  1  branch/cmov condition computed in execute
M_icode  input  4  icode in memory stage
m_stat  input  3  memory-stage status (1=AOK, 2=HLT, 3=ADR, 4=INS)
W_stat  input  3  writeback-stage status, same encoding
W_valid  input  1  W register holds a real instruction (not a bubble)
F_stall  output  1  hold fetch PC register
D_stall  output  1  hold D register
D_bubble  output  1  load nop into D
E_bubble  output  1  load nop into E
M_bubble  output  1  load nop into M
W_stall  output  1  hold W register
set_cc  output  1  write ZF/SF/OF this cycle
run_state  output  2  00=RUN, 01=DRAIN, 10=HALTED
cycle_cnt  output  CNT_W  cycles spent outside HALTED
retire_cnt  output  CNT_W  instructions retired with AOK
mispred_cnt  output  CNT_W  mispredicted conditional jumps
stall_cnt  output  CNT_W  cycles with F_stall due to hazard

Behaviour:
- Reset (rst_n low, asynchronous): run_state=RUN, all counters=0. While rst_n is low, all control outputs are forced to 0.
- Hazard terms:
  - load_use = (E_icode==5 or 11) and E_dstM!=15 and (E_dstM==d_srcA or E_dstM==d_srcB)
  - ret_pend = (D_icode==9 or E_icode==9 or M_icode==9)
  - mispred = E_icode==7 and e_Cnd==0
  - exc_m = m_stat!=1
  - exc_w = W_stat!=1
- Outputs in RUN and DRAIN:
  - F_stall = load_use or ret_pend
  - D_stall = load_use
  - D_bubble = mispred or (ret_pend and not load_use)
  - E_bubble = mispred or load_use
  - M_bubble = exc_m or exc_w
  - W_stall = exc_w
  - set_cc = (E_icode==6) and not exc_m and not exc_w
- D_stall and D_bubble are never both 1; load_use has priority over ret_pend.
- Mispredict plus load_use in the same cycle: E_bubble=1, D_bubble=1, D_stall=1. Downstream treats stall+bubble on D as bubble.
- HALTED outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0, independent of inputs.
- FSM, evaluated at posedge:
  - RUN -> HALTED if exc_w and W_valid.
  - RUN -> DRAIN if exc_m (and not the above).
  - DRAIN -> HALTED if exc_w and W_valid.
  - HALTED is terminal until reset.
  - Encoding 11 is illegal and recovers to HALTED next cycle.
- Counters: registered, modulo 2^CNT_W (wrap to 0, no saturation), all frozen in HALTED.
  - cycle_cnt +1 every cycle not in HALTED.
  - retire_cnt +1 when W_valid and W_stat==1 and not W_stall.
  - mispred_cnt +1 when mispred in RUN.
  - stall_cnt +1 when F_stall in RUN or DRAIN.
- Latency: control outputs are 0-cycle (same cycle as inputs). run_state and counters reflect a cycle's events after the next posedge.
- Reset asserted mid-operation: state and counters clear immediately, without waiting for a clock edge.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3, D_icode=6 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1 after edge. With E_dstM=15 and d_srcA=15 -> all 0.
- ret: D_icode=9 for 1 cycle, then E_icode=9, then M_icode=9 -> F_stall=1, D_bubble=1 for 3 consecutive cycles; cleared when no stage holds 9.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, mispred_cnt 0->1. e_Cnd=1 -> no bubble, count unchanged.
- Exception drain: E_icode=6 with m_stat=3 -> set_cc=0, M_bubble=1, run_state=01 next cycle. Then W_stat=3, W_valid=1 -> W_stall=1, run_state=10 next cycle. Further 10 cycles: cycle_cnt and retire_cnt unchanged, set_cc=0.
- HALT retire: W_stat=2, W_valid=1 in RUN -> HALTED directly; retire_cnt does not count the halt instruction.
- Wrap/reset: CNT_W=4, run 17 cycles -> cycle_cnt=1. Assert rst_n=0 between edges -> counters=0 and run_state=00 immediately, all control outputs 0.
